// File: rtl/ins_ram_ctrl.sv
// Instruction-memory controller: fixed-latency fetch port toward the cpu core
// plus a loader write port for program download into the same RAM.
module ins_ram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ram_in,
  input  logic [15:0]       addr,
  output logic [DATA_W-1:0] ins,
  output logic              en_ram_out,
  output logic              busy,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              oor_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_q_r, addr_q_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              rd_en_s;
  logic              oor_set_s;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Next-state, latency countdown and RAM read strobe.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    addr_q_s  = addr_q_r;
    rd_addr_s = addr_q_r;
    rd_en_s   = 1'b0;
    oor_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (en_ram_in) begin
          addr_q_s  = addr[ADDR_W-1:0];
          cnt_s     = CNT_INIT;
          oor_set_s = ((addr >> ADDR_W) != 16'd0);
          // Single-cycle latency reads straight from the request address.
          if (RD_LAT == 1) begin
            rd_addr_s = addr[ADDR_W-1:0];
            rd_en_s   = 1'b1;
            state_s   = RESP;
          end else begin
            state_s   = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          rd_en_s = 1'b1;
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, registered outputs and the read-first RAM read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_q_r   <= {ADDR_W{1'b0}};
      ins        <= {DATA_W{1'b0}};
      en_ram_out <= 1'b0;
      busy       <= 1'b0;
      oor_err    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      addr_q_r   <= addr_q_s;
      en_ram_out <= (state_s == RESP);
      busy       <= (state_s != IDLE);
      if (rd_en_s) begin
        ins <= mem[rd_addr_s];
      end
      if (oor_set_s) begin
        oor_err <= 1'b1;
      end
    end
  end

  // Loader write port; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_we && !rst) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule
